fifo_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_ns.sv | 46 ++++
 rtl/fifo_ctrl.sv | 107 ++++++++++
 tb/tb_fifo_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the 8-entry FIFO control slice.
// Contents:
//   DEPTH_DEF / AW_DEF / CW_DEF   default depth, pointer width and count width
//   fifo_state_e                  3-bit operation codes (110/111 unused)
package fifo_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int AW_DEF    = 3;
    localparam int CW_DEF    = AW_DEF + 1;

    typedef enum logic [2:0] {
        INIT   = 3'b000,
        WRITE  = 3'b001,
        WR_ERR = 3'b010,
        NO_OP  = 3'b011,
        READ   = 3'b100,
        RD_ERR = 3'b101
    } fifo_state_e;

endpackage

// File: rtl/fifo_ns.sv
// fifo_ns: combinational per-cycle operation decision.
// Ports:
//   wr_en, rd_en   requests sampled this cycle
//   data_count     registered occupancy (0..DEPTH)
//   next_state     operation code committed at the next rising edge
//   we, re         write/read enables (never both 1)
module fifo_ns
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [AW:0] data_count,
    output fifo_state_e next_state,
    output logic        we,
    output logic        re
);

    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    // A lone request is honoured unless it would overflow/underflow; two
    // simultaneous requests are both dropped (NO_OP), as is an idle cycle.
    always_comb begin
        next_state = NO_OP;
        we         = 1'b0;
        re         = 1'b0;
        if (wr_en && !rd_en) begin
            if (data_count == COUNT_FULL) begin
                next_state = WR_ERR;
            end else begin
                next_state = WRITE;
                we         = 1'b1;
            end
        end else if (rd_en && !wr_en) begin
            if (data_count == '0) begin
                next_state = RD_ERR;
            end else begin
                next_state = READ;
                re         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: sequential control stage of the 8-entry FIFO.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   wr_en, rd_en          per-cycle write/read requests
//   we, re                enables to the register file (combinational)
//   waddr, raddr          current tail / head
//   state                 registered code of the last decided operation
//   head, tail            registered read / write pointers
//   data_count            registered occupancy 0..DEPTH
//   full, empty           decoded from data_count
//   wr_ack, wr_err,
//   rd_ack, rd_err        registered decodes of the committed operation
//
// Request/enable semantics: wr_en/rd_en are one-cycle requests with no
// back-pressure. A request is accepted exactly when the matching enable
// (we/re) is high in that cycle; the transfer happens at waddr/raddr on the
// following rising edge, and its outcome appears on the ack/err outputs
// one cycle after the request.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic          we,
    output logic          re,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] raddr,
    output logic [2:0]    state,
    output logic [AW-1:0] head,
    output logic [AW-1:0] tail,
    output logic [AW:0]   data_count,
    output logic          full,
    output logic          empty,
    output logic          wr_ack,
    output logic          wr_err,
    output logic          rd_ack,
    output logic          rd_err
);

    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    fifo_state_e   state_q;
    fifo_state_e   next_state;
    logic          ns_we;
    logic          ns_re;
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [AW:0]   count_q;

    fifo_ns #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ns (
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .data_count (count_q),
        .next_state (next_state),
        .we         (ns_we),
        .re         (ns_re)
    );

    // Pointers wrap naturally because DEPTH is a power of two. Any stray
    // 110/111 state code is simply replaced by the next decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wr_ack  <= 1'b0;
            wr_err  <= 1'b0;
            rd_ack  <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            state_q <= next_state;
            if (ns_we) begin
                tail_q  <= tail_q + 1'b1;
                count_q <= count_q + 1'b1;
            end else if (ns_re) begin
                head_q  <= head_q + 1'b1;
                count_q <= count_q - 1'b1;
            end
            wr_ack <= (next_state == WRITE);
            wr_err <= (next_state == WR_ERR);
            rd_ack <= (next_state == READ);
            rd_err <= (next_state == RD_ERR);
        end
    end

    // Reset suppresses the enables so no transfer happens on a reset edge.
    assign we         = ns_we && !reset;
    assign re         = ns_re && !reset;
    assign waddr      = tail_q;
    assign raddr      = head_q;
    assign state      = state_q;
    assign head       = head_q;
    assign tail       = tail_q;
    assign data_count = count_q;
    assign full       = (count_q == COUNT_FULL);
    assign empty      = (count_q == '0);

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl. Written addresses are queued
// and popped on reads to check raddr order.
module tb_fifo_ctrl;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic          rd_en;
    logic          we;
    logic          re;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [2:0]    state;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   data_count;
    logic          full;
    logic          empty;
    logic          wr_ack;
    logic          wr_err;
    logic          rd_ack;
    logic          rd_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr;

    fifo_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .we         (we),
        .re         (re),
        .waddr      (waddr),
        .raddr      (raddr),
        .state      (state),
        .head       (head),
        .tail       (tail),
        .data_count (data_count),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive inputs just after a rising edge.
    task automatic drive(input logic rst, input logic wr, input logic rd);
        reset = rst;
        wr_en = wr;
        rd_en = rd;
        #1;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();

        // Reset with wr_en held
        drive(1'b1, 1'b1, 1'b0);
        check("rst_we", 32'(we), 0);
        check("rst_re", 32'(re), 0);
        tick();
        check("rst_state", 32'(state), 0);
        check("rst_head", 32'(head), 0);
        check("rst_tail", 32'(tail), 0);
        check("rst_count", 32'(data_count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_wr_ack", 32'(wr_ack), 0);
        check("rst_rd_err", 32'(rd_err), 0);

        // Fill: 8 writes from empty
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            check("fill_we", 32'(we), 1);
            check("fill_re", 32'(re), 0);
            check("fill_waddr", 32'(waddr), 32'(i));
            exp_q.push_back(waddr);
            tick();
            check("fill_tail", 32'(tail), 32'((i + 1) % 8));
            check("fill_count", 32'(data_count), 32'(i + 1));
            check("fill_state", 32'(state), 1);
            check("fill_wr_ack", 32'(wr_ack), 1);
        end
        check("fill_full", 32'(full), 1);
        check("fill_empty", 32'(empty), 0);

        // Write while full
        drive(1'b0, 1'b1, 1'b0);
        check("ovf_we", 32'(we), 0);
        tick();
        check("ovf_state", 32'(state), 2);
        check("ovf_wr_err", 32'(wr_err), 1);
        check("ovf_wr_ack", 32'(wr_ack), 0);
        check("ovf_tail", 32'(tail), 0);
        check("ovf_count", 32'(data_count), 8);

        // Drain: 8 reads from full
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            check("drain_re", 32'(re), 1);
            check("drain_we", 32'(we), 0);
            exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("drain_raddr", 32'(raddr), 32'(exp_addr));
            tick();
            check("drain_head", 32'(head), 32'((i + 1) % 8));
            check("drain_count", 32'(data_count), 32'(7 - i));
            check("drain_state", 32'(state), 4);
            check("drain_rd_ack", 32'(rd_ack), 1);
        end
        check("drain_empty", 32'(empty), 1);
        check("drain_full", 32'(full), 0);

        // Read while empty
        drive(1'b0, 1'b0, 1'b1);
        check("udf_re", 32'(re), 0);
        tick();
        check("udf_state", 32'(state), 5);
        check("udf_rd_err", 32'(rd_err), 1);
        check("udf_rd_ack", 32'(rd_ack), 0);
        check("udf_head", 32'(head), 0);
        check("udf_count", 32'(data_count), 0);

        // Three writes, then simultaneous requests and an idle cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            tick();
        end
        check("pre_both_count", 32'(data_count), 3);
        drive(1'b0, 1'b1, 1'b1);
        check("both_we", 32'(we), 0);
        check("both_re", 32'(re), 0);
        tick();
        check("both_state", 32'(state), 3);
        check("both_head", 32'(head), 0);
        check("both_tail", 32'(tail), 3);
        check("both_count", 32'(data_count), 3);
        check("both_wr_ack", 32'(wr_ack), 0);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        check("idle_state", 32'(state), 3);
        check("idle_count", 32'(data_count), 3);

        // Two more writes (five in this burst), then reset mid-burst
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            tick();
        end
        check("burst_tail", 32'(tail), 5);
        check("burst_count", 32'(data_count), 5);
        drive(1'b1, 1'b1, 1'b0);
        check("midrst_we", 32'(we), 0);
        tick();
        check("midrst_state", 32'(state), 0);
        check("midrst_head", 32'(head), 0);
        check("midrst_tail", 32'(tail), 0);
        check("midrst_count", 32'(data_count), 0);
        check("midrst_wr_ack", 32'(wr_ack), 0);
        check("midrst_empty", 32'(empty), 1);

        // First write after reset lands at address 0
        drive(1'b0, 1'b1, 1'b0);
        check("post_waddr", 32'(waddr), 0);
        check("post_we", 32'(we), 1);
        tick();
        check("post_tail", 32'(tail), 1);
        check("post_count", 32'(data_count), 1);
        check("post_wr_ack", 32'(wr_ack), 1);

        drive(1'b0, 1'b0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
